// File: rtl/xout_frame_accum_if.sv
// xout_frame_accum_if: sample-in / frame-result-out handshake bundle
interface xout_frame_accum_if #(parameter int ACC_W = 16);
  logic [7:0]       XIN;
  logic             XIN_VALID;
  logic             XIN_READY;
  logic [ACC_W-1:0] SUM;
  logic [7:0]       MAXV;
  logic             OUT_VALID;
  logic             OUT_READY;
  modport master (output XIN, XIN_VALID, OUT_READY, input XIN_READY, SUM, MAXV, OUT_VALID);
  modport slave  (input XIN, XIN_VALID, OUT_READY, output XIN_READY, SUM, MAXV, OUT_VALID);
endinterface

// File: rtl/xout_frame_accum.sv
// xout_frame_accum: sums and maxes FRAME_LEN accepted samples, holds the result until consumed
module xout_frame_accum #(
  parameter int FRAME_LEN = 4,
  parameter int ACC_W     = 16
) (
  input logic CLK,
  input logic RST,
  xout_frame_accum_if.slave bus
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  typedef enum logic {ACCUM, HOLD} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d, sum_q, sum_d, acc_next;
  logic [7:0]       mx_q, mx_d, maxv_q, maxv_d, mx_next;
  logic             ov_q, ov_d, accept, last, consume;
  always_comb begin
    accept   = state_q == ACCUM && bus.XIN_VALID;
    last     = accept && cnt_q == CW'(FRAME_LEN - 1);
    consume  = state_q == HOLD && bus.OUT_READY;
    acc_next = acc_q + ACC_W'(bus.XIN);
    mx_next  = bus.XIN > mx_q ? bus.XIN : mx_q;
    state_d  = last ? HOLD : consume ? ACCUM : state_q;
    cnt_d    = last ? '0 : accept ? cnt_q + CW'(1) : cnt_q;
    acc_d    = last ? '0 : accept ? acc_next : acc_q;
    mx_d     = last ? '0 : accept ? mx_next : mx_q;
    sum_d    = last ? acc_next : sum_q;
    maxv_d   = last ? mx_next : maxv_q;
    ov_d     = last ? 1'b1 : consume ? 1'b0 : ov_q;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ACCUM;
      cnt_q   <= '0;
      acc_q   <= '0;
      mx_q    <= '0;
      sum_q   <= '0;
      maxv_q  <= '0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mx_q    <= mx_d;
      sum_q   <= sum_d;
      maxv_q  <= maxv_d;
      ov_q    <= ov_d;
    end
  end
  assign bus.XIN_READY = state_q == ACCUM;
  assign bus.SUM       = sum_q;
  assign bus.MAXV      = maxv_q;
  assign bus.OUT_VALID = ov_q;
endmodule

// File: tb/tb_xout_frame_accum.sv
// tb_xout_frame_accum: three configurations driven by one stimulus stream, checked against a frame-level model
module tb_xout_frame_accum;
  logic       CLK, RST;
  logic [7:0] xin;
  logic       xv, ordy;
  int n_checks = 0, n_errors = 0;

  xout_frame_accum_if #(.ACC_W(16)) b0 ();
  xout_frame_accum_if #(.ACC_W(8))  b1 ();
  xout_frame_accum_if #(.ACC_W(16)) b2 ();
  assign b0.XIN = xin; assign b0.XIN_VALID = xv; assign b0.OUT_READY = ordy;
  assign b1.XIN = xin; assign b1.XIN_VALID = xv; assign b1.OUT_READY = ordy;
  assign b2.XIN = xin; assign b2.XIN_VALID = xv; assign b2.OUT_READY = ordy;

  xout_frame_accum #(.FRAME_LEN(4), .ACC_W(16)) u0 (.CLK(CLK), .RST(RST), .bus(b0));
  xout_frame_accum #(.FRAME_LEN(4), .ACC_W(8))  u1 (.CLK(CLK), .RST(RST), .bus(b1));
  xout_frame_accum #(.FRAME_LEN(1), .ACC_W(16)) u2 (.CLK(CLK), .RST(RST), .bus(b2));

  initial begin
    CLK = 0;
    forever #5 CLK = ~CLK;
  end

  int fl[3] = '{4, 4, 1};
  int aw[3] = '{16, 8, 16};
  int smp[3][256];
  int n[3];
  bit hold[3];
  int e_sum[3], e_max[3];

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
    end
  endtask

  // Frame-level reference: collect samples, reduce the whole frame when it completes.
  task automatic model_edge(input logic r, input int x, input logic v, input logic o);
    for (int i = 0; i < 3; i++) begin
      if (r) begin
        n[i] = 0; hold[i] = 0; e_sum[i] = 0; e_max[i] = 0;
      end else if (hold[i]) begin
        if (o) hold[i] = 0;
      end else if (v) begin
        smp[i][n[i]] = x;
        n[i]++;
        if (n[i] == fl[i]) begin
          longint tot = 0;
          int m = 0;
          for (int k = 0; k < fl[i]; k++) begin
            tot += smp[i][k];
            if (smp[i][k] > m) m = smp[i][k];
          end
          e_sum[i] = int'(tot % (64'd1 << aw[i]));
          e_max[i] = m;
          hold[i] = 1;
          n[i] = 0;
        end
      end
    end
  endtask

  task automatic chk_model;
    chk("u0_rdy", int'(b0.XIN_READY), int'(!hold[0]));
    chk("u0_ov",  int'(b0.OUT_VALID), int'(hold[0]));
    chk("u0_sum", int'(b0.SUM), e_sum[0]);
    chk("u0_max", int'(b0.MAXV), e_max[0]);
    chk("u1_rdy", int'(b1.XIN_READY), int'(!hold[1]));
    chk("u1_ov",  int'(b1.OUT_VALID), int'(hold[1]));
    chk("u1_sum", int'(b1.SUM), e_sum[1]);
    chk("u1_max", int'(b1.MAXV), e_max[1]);
    chk("u2_rdy", int'(b2.XIN_READY), int'(!hold[2]));
    chk("u2_ov",  int'(b2.OUT_VALID), int'(hold[2]));
    chk("u2_sum", int'(b2.SUM), e_sum[2]);
    chk("u2_max", int'(b2.MAXV), e_max[2]);
  endtask

  task automatic cyc(input logic r, input logic [7:0] x, input logic v, input logic o);
    RST = r; xin = x; xv = v; ordy = o;
    @(posedge CLK);
    model_edge(r, int'(x), v, o);
    #1;
    chk_model();
  endtask

  typedef struct {
    logic r; logic [7:0] x; logic v; logic o;
    int sum; int mx; logic ov; logic rdy;
  } vec_t;

  initial begin
    vec_t tbl[16];
    tbl[0]  = '{1, 0,  0, 0,   0,  0, 0, 1};
    tbl[1]  = '{0, 3,  1, 1,   0,  0, 0, 1};
    tbl[2]  = '{0, 7,  1, 1,   0,  0, 0, 1};
    tbl[3]  = '{0, 5,  1, 1,   0,  0, 0, 1};
    tbl[4]  = '{0, 1,  1, 1,  16,  7, 1, 0};
    tbl[5]  = '{0, 9,  1, 1,  16,  7, 0, 1};
    tbl[6]  = '{0, 0,  0, 1,  16,  7, 0, 1};
    tbl[7]  = '{0, 10, 1, 1,  16,  7, 0, 1};
    tbl[8]  = '{0, 99, 0, 1,  16,  7, 0, 1};
    tbl[9]  = '{0, 20, 1, 1,  16,  7, 0, 1};
    tbl[10] = '{0, 99, 0, 1,  16,  7, 0, 1};
    tbl[11] = '{0, 30, 1, 1,  16,  7, 0, 1};
    tbl[12] = '{0, 99, 0, 1,  16,  7, 0, 1};
    tbl[13] = '{0, 40, 1, 1, 100, 40, 1, 0};
    tbl[14] = '{0, 99, 0, 1, 100, 40, 0, 1};
    tbl[15] = '{0, 99, 0, 1, 100, 40, 0, 1};
    tbl[5].x = 0;
    for (int i = 0; i < 16; i++) begin
      cyc(tbl[i].r, tbl[i].x, tbl[i].v, tbl[i].o);
      chk($sformatf("tbl%0d_sum", i), int'(b0.SUM), tbl[i].sum);
      chk($sformatf("tbl%0d_max", i), int'(b0.MAXV), tbl[i].mx);
      chk($sformatf("tbl%0d_ov", i), int'(b0.OUT_VALID), int'(tbl[i].ov));
      chk($sformatf("tbl%0d_rdy", i), int'(b0.XIN_READY), int'(tbl[i].rdy));
    end

    // result held while downstream stalls, samples ignored
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0); cyc(0, 2, 1, 0); cyc(0, 3, 1, 0); cyc(0, 4, 1, 0);
    for (int i = 0; i < 5; i++) begin
      cyc(0, 8'($urandom), 1, 0);
      chk("stall_sum", int'(b0.SUM), 10);
      chk("stall_max", int'(b0.MAXV), 4);
      chk("stall_ov", int'(b0.OUT_VALID), 1);
      chk("stall_rdy", int'(b0.XIN_READY), 0);
    end
    cyc(0, 200, 1, 1);
    chk("release_ov", int'(b0.OUT_VALID), 0);
    chk("release_rdy", int'(b0.XIN_READY), 1);
    cyc(0, 5, 1, 1); cyc(0, 6, 1, 1); cyc(0, 7, 1, 1); cyc(0, 8, 1, 1);
    chk("next_sum", int'(b0.SUM), 26);
    chk("next_max", int'(b0.MAXV), 8);
    chk("next_ov", int'(b0.OUT_VALID), 1);

    // 8-bit accumulator wraps silently
    cyc(1, 0, 0, 0);
    cyc(0, 200, 1, 1); cyc(0, 100, 1, 1); cyc(0, 50, 1, 1); cyc(0, 10, 1, 1);
    chk("wrap_sum8", int'(b1.SUM), 104);
    chk("wrap_max8", int'(b1.MAXV), 200);
    chk("wrap_sum16", int'(b0.SUM), 360);

    // reset mid-frame discards partial samples
    cyc(1, 0, 0, 1);
    cyc(0, 9, 1, 1); cyc(0, 9, 1, 1);
    cyc(1, 9, 1, 1);
    chk("rst_ov", int'(b0.OUT_VALID), 0);
    chk("rst_sum", int'(b0.SUM), 0);
    cyc(0, 1, 1, 1); cyc(0, 2, 1, 1); cyc(0, 3, 1, 1); cyc(0, 4, 1, 1);
    chk("rst_frame_sum", int'(b0.SUM), 10);
    chk("rst_frame_max", int'(b0.MAXV), 4);

    // single-sample frames, one result every two cycles
    cyc(1, 0, 0, 1);
    cyc(0, 255, 1, 1);
    chk("fl1_a_sum", int'(b2.SUM), 255);
    chk("fl1_a_max", int'(b2.MAXV), 255);
    chk("fl1_a_ov", int'(b2.OUT_VALID), 1);
    cyc(0, 0, 1, 1);
    chk("fl1_gap_ov", int'(b2.OUT_VALID), 0);
    cyc(0, 0, 1, 1);
    chk("fl1_b_sum", int'(b2.SUM), 0);
    chk("fl1_b_max", int'(b2.MAXV), 0);
    chk("fl1_b_ov", int'(b2.OUT_VALID), 1);

    // reset coinciding with the last accept wins
    cyc(1, 0, 0, 0);
    cyc(0, 1, 1, 0); cyc(0, 1, 1, 0); cyc(0, 1, 1, 0);
    cyc(1, 1, 1, 0);
    chk("rst_pri_ov", int'(b0.OUT_VALID), 0);

    for (int i = 0; i < 3000; i++)
      cyc(($urandom_range(63) == 0), 8'($urandom), 1'($urandom), ($urandom_range(3) != 0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
